bram_port_arbiter: RTL and testbench

- Shares the single read-only BRAM port A between two requesters: CPU instruction fetch (imem) and display scan-out fetch (vmem).
- Replaces the combinational address-select mux with a sequenced, round-robin arbiter, so neither requester starves.
- Returns byte-aligned read data to each requester.
- Reports the worst-case display wait, for tuning the display FIFO depth.

---
 rtl/bram_port_arbiter.sv | 176 +++++++++++++++++
 tb/tb_bram_port_arbiter.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/bram_port_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : bram_port_arbiter
//  Purpose  : Round-robin sequencer sharing read-only BRAM port A between
//             CPU instruction fetch (imem) and display scan-out (vmem).
//             Also tracks the worst-case display wait.
//  Revision : 1.0 - initial release
// ============================================================================
module bram_port_arbiter #(
  parameter int MEM_LATENCY = 1,   // address register to q valid, 1..3
  parameter int WAIT_W      = 8    // width of saturating wait counters
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              imem_valid,
  input  logic [14:0]       imem_addr,
  output logic              imem_ready,
  output logic [31:0]       imem_rdata,
  input  logic              vmem_valid,
  input  logic [16:0]       vmem_addr,
  output logic              vmem_ready,
  output logic [31:0]       vmem_rdata,
  output logic [14:0]       mem_addr,
  input  logic [31:0]       mem_rdata,
  output logic [WAIT_W-1:0] vmem_max_wait,
  input  logic              clr_max
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic       c_OWN_CPU  = 1'b0;
  localparam logic       c_OWN_VID  = 1'b1;
  localparam logic [1:0] c_LAT_LOAD = 2'(MEM_LATENCY - 1);
  localparam logic [WAIT_W-1:0] c_WAIT_ONE = {{(WAIT_W-1){1'b0}}, 1'b1};

  state_t            state_q, state_d;
  logic              owner_q, owner_d;
  logic              last_q, last_d;
  logic [14:0]       mem_addr_q, mem_addr_d;
  logic [1:0]        off_q, off_d;
  logic [1:0]        lat_q, lat_d;
  logic [WAIT_W-1:0] iwait_q, iwait_d;
  logic [WAIT_W-1:0] vwait_q, vwait_d;
  logic [WAIT_W-1:0] vmax_q, vmax_d;

  logic              w_grant;
  logic              w_grant_vid;

  // Sequencer: arbitration, latency count, completion pulse and hand-over.
  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    last_d      = last_q;
    mem_addr_d  = mem_addr_q;
    off_d       = off_q;
    lat_d       = lat_q;
    w_grant     = 1'b0;
    w_grant_vid = 1'b0;
    imem_ready  = 1'b0;
    vmem_ready  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        // Under contention the requester that was not served last wins.
        if (imem_valid || vmem_valid) begin
          w_grant     = 1'b1;
          w_grant_vid = vmem_valid && (!imem_valid || (last_q == c_OWN_CPU));
        end
      end
      ST_WAIT: begin
        if (lat_q == 2'd0) begin
          state_d = ST_DONE;
        end else begin
          lat_d = lat_q - 2'd1;
        end
      end
      ST_DONE: begin
        // The owner's valid is stale here; only the other side may chain in.
        last_d  = owner_q;
        state_d = ST_IDLE;
        if (owner_q == c_OWN_CPU) begin
          imem_ready = 1'b1;
          if (vmem_valid) begin
            w_grant     = 1'b1;
            w_grant_vid = 1'b1;
          end
        end else begin
          vmem_ready = 1'b1;
          if (imem_valid) begin
            w_grant     = 1'b1;
            w_grant_vid = 1'b0;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (w_grant) begin
      state_d = ST_WAIT;
      lat_d   = c_LAT_LOAD;
      owner_d = w_grant_vid;
      if (w_grant_vid) begin
        mem_addr_d = vmem_addr[16:2];
        off_d      = vmem_addr[1:0];
      end else begin
        mem_addr_d = imem_addr;
      end
    end
  end

  // Wait counters run while a request is pending and the port belongs to the
  // other side in the coming cycle; a grant clears them.
  always_comb begin
    iwait_d = iwait_q;
    vwait_d = vwait_q;
    vmax_d  = vmax_q;

    if (w_grant && !w_grant_vid) begin
      iwait_d = '0;
    end else if (imem_valid && (owner_d != c_OWN_CPU) && (iwait_q != '1)) begin
      iwait_d = iwait_q + c_WAIT_ONE;
    end

    if (w_grant && w_grant_vid) begin
      vwait_d = '0;
    end else if (vmem_valid && (owner_d != c_OWN_VID) && (vwait_q != '1)) begin
      vwait_d = vwait_q + c_WAIT_ONE;
    end

    if (clr_max) begin
      vmax_d = '0;
    end else if (w_grant && w_grant_vid && (vwait_q > vmax_q)) begin
      vmax_d = vwait_q;
    end
  end

  // State and datapath registers; reset aborts any transaction in flight.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q    <= ST_IDLE;
      owner_q    <= c_OWN_CPU;
      last_q     <= c_OWN_CPU;
      mem_addr_q <= '0;
      off_q      <= '0;
      lat_q      <= '0;
      iwait_q    <= '0;
      vwait_q    <= '0;
      vmax_q     <= '0;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      last_q     <= last_d;
      mem_addr_q <= mem_addr_d;
      off_q      <= off_d;
      lat_q      <= lat_d;
      iwait_q    <= iwait_d;
      vwait_q    <= vwait_d;
      vmax_q     <= vmax_d;
    end
  end

  // Read data is only meaningful during the matching ready pulse.
  always_comb begin
    imem_rdata = mem_rdata;
    vmem_rdata = mem_rdata >> {off_q, 3'b000};
  end

  assign mem_addr      = mem_addr_q;
  assign vmem_max_wait = vmax_q;

endmodule
`default_nettype wire

// File: tb/tb_bram_port_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_bram_port_arbiter
//  Purpose  : Directed self-checking bench for bram_port_arbiter, with one
//             instance at MEM_LATENCY=1/WAIT_W=8 and one at 3/2.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_bram_port_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic resetn;

  // Instance A: default parameters
  logic        a_iv, a_ir, a_vv, a_vr, a_clr;
  logic [14:0] a_ia, a_ma;
  logic [16:0] a_va;
  logic [31:0] a_id, a_vd, a_md;
  logic [7:0]  a_mx;

  // Instance B: MEM_LATENCY=3, WAIT_W=2
  logic        b_iv, b_ir, b_vv, b_vr, b_clr;
  logic [14:0] b_ia, b_ma;
  logic [16:0] b_va;
  logic [31:0] b_id, b_vd, b_md, b_s0, b_s1;
  logic [1:0]  b_mx;

  logic [31:0] mem [0:32767];

  int errors = 0;
  int checks = 0;

  bram_port_arbiter #(.MEM_LATENCY(1), .WAIT_W(8)) dut_a (
    .clk(clk), .resetn(resetn),
    .imem_valid(a_iv), .imem_addr(a_ia), .imem_ready(a_ir), .imem_rdata(a_id),
    .vmem_valid(a_vv), .vmem_addr(a_va), .vmem_ready(a_vr), .vmem_rdata(a_vd),
    .mem_addr(a_ma), .mem_rdata(a_md), .vmem_max_wait(a_mx), .clr_max(a_clr)
  );

  bram_port_arbiter #(.MEM_LATENCY(3), .WAIT_W(2)) dut_b (
    .clk(clk), .resetn(resetn),
    .imem_valid(b_iv), .imem_addr(b_ia), .imem_ready(b_ir), .imem_rdata(b_id),
    .vmem_valid(b_vv), .vmem_addr(b_va), .vmem_ready(b_vr), .vmem_rdata(b_vd),
    .mem_addr(b_ma), .mem_rdata(b_md), .vmem_max_wait(b_mx), .clr_max(b_clr)
  );

  // BRAM models: one-stage and three-stage read pipelines
  always @(posedge clk) a_md <= mem[a_ma];
  always @(posedge clk) begin
    b_s0 <= mem[b_ma];
    b_s1 <= b_s0;
    b_md <= b_s1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    for (int i = 0; i < 32768; i++) mem[i] = 32'hA5000000 | i;
    mem[15'h0010] = 32'hDEADBEEF;
    mem[15'h0020] = 32'h11223344;
    mem[15'h0030] = 32'hCAFEF00D;
    mem[15'h0040] = 32'h01020304;

    resetn = 1'b0;
    a_iv = 0; a_vv = 0; a_ia = '0; a_va = '0; a_clr = 0;
    b_iv = 0; b_vv = 0; b_ia = '0; b_va = '0; b_clr = 0;

    // Reset state
    #12;
    chk("rst_iready", a_ir, 0);
    chk("rst_vready", a_vr, 0);
    chk("rst_maddr",  a_ma, 0);
    chk("rst_vmax",   a_mx, 0);
    tick;
    resetn = 1'b1;

    // CPU single read: ready exactly one cycle, 2 edges after first sample
    a_iv = 1; a_ia = 15'h0010;
    tick;
    chk("t1_maddr",  a_ma, 32'h10);
    chk("t1_ir_w",   a_ir, 0);
    tick;
    chk("t1_ir",     a_ir, 1);
    chk("t1_idata",  a_id, 32'hDEADBEEF);
    chk("t1_vr",     a_vr, 0);
    a_iv = 0;
    tick;
    chk("t1_ir_off", a_ir, 0);

    // vmem read with byte offset 2
    a_vv = 1; a_va = 17'h00042;
    tick;
    chk("t2_maddr",  a_ma, 32'h10);
    chk("t2_vr_w",   a_vr, 0);
    tick;
    chk("t2_vr",     a_vr, 1);
    chk("t2_vdata",  a_vd, 32'h0000DEAD);
    chk("t2_ir",     a_ir, 0);
    a_vv = 0;
    tick;
    chk("t2_vr_off", a_vr, 0);

    // Fresh reset, then both valid at once: vmem first, CPU chained from DONE
    resetn = 1'b0;
    tick;
    resetn = 1'b1;
    a_iv = 1; a_ia = 15'h0020;
    a_vv = 1; a_va = 17'h00043;
    tick;
    chk("t3_maddr_v", a_ma, 32'h10);
    tick;
    chk("t3_vr",      a_vr, 1);
    chk("t3_vdata",   a_vd, 32'h000000DE);
    chk("t3_ir0",     a_ir, 0);
    a_vv = 0;
    tick;
    chk("t3_maddr_c", a_ma, 32'h20);
    chk("t3_ir_w",    a_ir, 0);
    chk("t3_vr_off",  a_vr, 0);
    tick;
    chk("t3_ir",      a_ir, 1);
    chk("t3_idata",   a_id, 32'h11223344);
    a_iv = 0;
    tick;
    chk("t3_vmax",    a_mx, 0);

    // Full contention for 8 grants, starting with vmem (last was CPU)
    a_iv = 1; a_ia = 15'h0030;
    a_vv = 1; a_va = 17'h00081;
    tick;
    for (int i = 0; i < 16; i++) begin
      chk("t4_vr", a_vr, ((i % 4) == 1) ? 1 : 0);
      chk("t4_ir", a_ir, ((i % 4) == 3) ? 1 : 0);
      if ((i % 4) == 1) chk("t4_vdata", a_vd, 32'h00112233);
      if ((i % 4) == 3) chk("t4_idata", a_id, 32'hCAFEF00D);
      if (i < 15) tick;
    end
    a_iv = 0; a_vv = 0;
    tick;
    chk("t4_vmax",  a_mx, 2);
    chk("t4_idle",  {a_ir, a_vr}, 0);

    // Reset during WAIT of a CPU read aborts it; request is re-served
    a_iv = 1; a_ia = 15'h0040;
    tick;
    chk("t5_maddr_pre", a_ma, 32'h40);
    resetn = 1'b0;
    #1;
    chk("t5_rst_ir",    a_ir, 0);
    chk("t5_rst_vr",    a_vr, 0);
    chk("t5_rst_maddr", a_ma, 0);
    chk("t5_rst_vmax",  a_mx, 0);
    tick;
    chk("t5_rst_ir2",   a_ir, 0);
    resetn = 1'b1;
    tick;
    chk("t5_maddr",     a_ma, 32'h40);
    chk("t5_ir_w",      a_ir, 0);
    tick;
    chk("t5_ir",        a_ir, 1);
    chk("t5_idata",     a_id, 32'h01020304);
    a_iv = 0;
    tick;
    chk("t5_ir_off",    a_ir, 0);

    // Instance B: vmem-only read first so that last=vmem
    b_vv = 1; b_va = 17'h00040;
    tick;
    chk("t6_vr_w0", b_vr, 0);
    tick;
    tick;
    chk("t6_vr_w2", b_vr, 0);
    tick;
    chk("t6_vr",    b_vr, 1);
    chk("t6_vdata", b_vd, 32'hDEADBEEF);
    b_vv = 0;
    tick;
    chk("t6_vmax0", b_mx, 0);

    // CPU wins the contended grant and holds the port; vmem waits and saturates
    b_iv = 1; b_ia = 15'h0020;
    b_vv = 1; b_va = 17'h00082;
    tick;
    chk("t6_maddr_c", b_ma, 32'h20);
    tick;
    tick;
    tick;
    chk("t6_ir",      b_ir, 1);
    chk("t6_idata",   b_id, 32'h11223344);
    chk("t6_vr0",     b_vr, 0);
    b_iv = 0;
    tick;
    chk("t6_vmax_sat", b_mx, 3);
    chk("t6_maddr_v",  b_ma, 32'h20);
    tick;
    tick;
    tick;
    chk("t6_vr2",     b_vr, 1);
    chk("t6_vdata2",  b_vd, 32'h00001122);
    b_vv = 0;
    b_clr = 1;
    tick;
    b_clr = 0;
    chk("t6_vmax_clr", b_mx, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
